// File: rtl/ecdsa_defs.sv
// Shared secp256k1 datapath definitions: widths, field constants and the
// multiplier FSM state encoding.
package ecdsa_defs;

  localparam int FE_W   = 256;
  localparam int PROD_W = 512;

  localparam logic [FE_W-1:0] FIELD_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [FE_W-1:0] ORDER_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_digit.sv
// Combinational 256 x DIGIT_W -> 256+DIGIT_W unsigned partial-product multiplier.
module mul_digit
  import ecdsa_defs::*;
#(
  parameter int DIGIT_W = 32
) (
  input  logic [FE_W-1:0]         a,
  input  logic [DIGIT_W-1:0]      digit,
  output logic [FE_W+DIGIT_W-1:0] prod
);

  assign prod = {{DIGIT_W{1'b0}}, a} * {{FE_W{1'b0}}, digit};

endmodule

// File: rtl/mul256_digit_serial.sv
// Digit-serial 256x256 -> 512 unsigned multiplier, one DIGIT_W digit of b per cycle.
// Optional early termination on all-zero remaining digits: MUL_ZERO_SKIP_EN.
module mul256_digit_serial
  import ecdsa_defs::*;
#(
  parameter int DIGIT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FE_W-1:0]   a,
  input  logic [FE_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p
);

  localparam int NUM_DIGITS = FE_W / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Handshake: start is taken only when busy=0 (including the done cycle);
  // busy then stays high until the edge that raises done for one cycle with p valid.
  state_t state, state_next;

  logic [FE_W-1:0]         a_r;
  logic [FE_W-1:0]         b_r;
  logic [PROD_W-1:0]       acc;
  logic [CNT_W-1:0]        cnt;
  logic [FE_W+DIGIT_W-1:0] pp;
  logic [PROD_W-1:0]       pp_shifted;
  logic [8:0]              shamt;
  logic                    last_digit;
  logic                    load;
  logic                    step;
  logic                    finish;

  mul_digit #(.DIGIT_W(DIGIT_W)) u_mul_digit (
    .a     (a_r),
    .digit (b_r[DIGIT_W-1:0]),
    .prod  (pp)
  );

  assign shamt      = 9'(cnt) * 9'(DIGIT_W);
  assign pp_shifted = PROD_W'(pp) << shamt;

`ifdef MUL_ZERO_SKIP_EN
  logic remaining_zero;
  assign remaining_zero = (b_r >> DIGIT_W) == '0;
  assign last_digit     = (cnt == CNT_W'(NUM_DIGITS - 1)) || remaining_zero;
`else
  assign last_digit = (cnt == CNT_W'(NUM_DIGITS - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL;
      MUL:     if (last_digit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) && start;
    step   = (state == MUL);
    finish = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      p    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_r  <= a;
        b_r  <= b;
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end
      if (step) begin
        acc <= acc + pp_shifted;
        b_r <= b_r >> DIGIT_W;
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        p    <= acc;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul256_digit_serial.sv
// Scoreboard bench for mul256_digit_serial: directed corner cases plus random operands
// checked against plain-arithmetic product and latency models.
module tb_mul256_digit_serial;

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] a;
  logic [255:0] b;
  logic         busy;
  logic         done;
  logic [511:0] p;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [511:0] exp_q[$];
  int           lat_q[$];
  int           t_q[$];

  localparam logic [255:0] FP =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  mul256_digit_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference models ----------------
  function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] xx;
    logic [511:0] yy;
    xx = {256'd0, x};
    yy = {256'd0, y};
    return xx * yy;
  endfunction

  function automatic int ref_lat(input logic [255:0] y);
`ifdef MUL_ZERO_SKIP_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 8; i++)
      if (((y >> (32 * i)) & 256'hFFFF_FFFF) != 256'd0) hi = i;
    return hi + 2;
`else
    return (y == y) ? 9 : 9;
`endif
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Leaves the caller on a negedge where busy=0 (the done cycle when one is pending).
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  // Drives a start from the current negedge; expected response goes to the scoreboard.
  task automatic drive(input logic [255:0] x, input logic [255:0] y, input logic [511:0] e);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    lat_q.push_back(ref_lat(y));
    t_q.push_back(cyc);
    start = 1'b0;
    a     = rand256();
    b     = rand256();
  endtask

  task automatic send(input logic [255:0] x, input logic [255:0] y, input logic [511:0] e);
    wait_idle();
    drive(x, y, e);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done && busy) begin
        checks++;
        errors++;
        $display("FAIL done_busy_overlap: done=%0b busy=%0b", done, busy);
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: p=%0h with empty queue", p);
        end else begin
          logic [511:0] e;
          int           l;
          int           t;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          t = t_q.pop_front();
          if (p !== e) begin
            errors++;
            $display("FAIL product: got %0h expected %0h", p, e);
          end
          checks++;
          if (cyc - t != l) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", cyc - t, l);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] x;
    logic [255:0] y;
    int           lat;
    int           n;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 512'(busy), 512'd0);
    check("reset_done", 512'(done), 512'd0);
    check("reset_p", p, 512'd0);

    // 1: 1*1 with busy window checked cycle by cycle
    send(256'd1, 256'd1, 512'd1);
    lat = ref_lat(256'd1);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("t1_busy", 512'(busy), 512'd1);
      check("t1_no_done", 512'(done), 512'd0);
    end

    // 2: all-ones squared
    send({256{1'b1}}, {256{1'b1}}, {~256'd1, 256'd1});
    // 3: 2*FIELD_P and 2^255*2^255
    send(FP, 256'd2, {256'd0, FP} << 1);
    send(256'd1 << 255, 256'd1 << 255, 512'd1 << 510);
    send(256'd0, rand256(), 512'd0);

    // 4: start while busy is ignored; start in the done cycle is taken
    send(256'd3, 256'd5, 512'd15);
`ifdef MUL_ZERO_SKIP_EN
    n = 1;
`else
    n = 3;
`endif
    repeat (n) @(negedge clk);
    check("t4_busy_at_pulse", 512'(busy), 512'd1);
    a     = 256'd7;
    b     = 256'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    check("t4_done_cycle", 512'(done), 512'd1);
    drive(256'd4, 256'd4, 512'd16);

    // 5: reset during MUL aborts with no done pulse
    send(rand256(), {1'b1, 255'd5}, 512'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", 512'(busy), 512'd0);
    check("t5_rst_done", 512'(done), 512'd0);
    check("t5_rst_p", p, 512'd0);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    t_q.delete();
    send(256'd2, 256'd3, 512'd6);

    // 6: short multiplier, then random operands with some sparse b
    x = rand256();
    send(x, 256'd3, ref_mul(x, 256'd3));
    for (int i = 0; i < 1000; i++) begin
      x = rand256();
      y = rand256();
      if ($urandom_range(0, 3) == 0) y = y >> (32 * $urandom_range(1, 8));
      send(x, y, ref_mul(x, y));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
